// File: rtl/data_sampler_window_fifo.sv
// data_sampler_window_fifo: records DIN_VALID samples into a DEPTH-deep ring,
// captures a pre/post window around a TRIG rising edge, freezes the ring and
// streams the window oldest-first as LSB-first DOUT_WIDTH words through a FWFT port.
// Optional: DATA_SAMPLER_TIMESTAMP_EN prepends a trigger timestamp header word.
module data_sampler_window_fifo #(
  parameter int DIN_WIDTH  = 512,
  parameter int DOUT_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     TRIG,
  input  logic [DIN_WIDTH-1:0]     DIN,
  input  logic                     DIN_VALID,
  input  logic [$clog2(DEPTH):0]   POST_CNT,
  output logic [DOUT_WIDTH-1:0]    DOUT,
  output logic                     DOUT_EMPTY,
  input  logic                     DOUT_RDEN,
  output logic                     BUSY,
  output logic [CNT_WIDTH-1:0]     TRIG_MISSED
);

  localparam int AW = $clog2(DEPTH);
  localparam int W  = DIN_WIDTH / DOUT_WIDTH;
  localparam int WW = (W > 1) ? $clog2(W) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {ARMED, POST, READOUT} state_t;

  state_t              state;
  logic                trig_q;
  logic [AW-1:0]       wr_ptr, wr_ptr_nxt, rd_ptr, rd_cnt;
  logic [AW:0]         fill, post_rem, rem_a;
  logic [WW-1:0]       widx;
  logic                prime, strm, src_done;
  logic                edge_det, accept, we, freeze, missed_inc;
  logic [DIN_WIDTH-1:0]  ring [DEPTH];
  logic [DIN_WIDTH-1:0]  cur_sample;
  logic [DOUT_WIDTH-1:0] cur_word;
`ifdef DATA_SAMPLER_TIMESTAMP_EN
  logic [DOUT_WIDTH-1:0] ts_cnt, ts_lat;
  logic                  hdr;
`endif

  // Trigger acceptance, ring write enable and freeze decision for this cycle
  always_comb begin
    edge_det   = TRIG & ~trig_q;
    accept     = (state == ARMED) && edge_det && (fill >= (DEPTH_C - POST_CNT));
    rem_a      = POST_CNT - (AW+1)'(DIN_VALID);
    we         = 1'b0;
    freeze     = 1'b0;
    missed_inc = edge_det && !accept;
    case (state)
      ARMED: begin
        // post=0 freezes before the edge-cycle sample is stored
        we     = DIN_VALID && !(accept && (POST_CNT == '0));
        freeze = accept && ((POST_CNT == '0) || (rem_a == '0));
      end
      POST: begin
        we     = DIN_VALID;
        freeze = DIN_VALID && (post_rem == (AW+1)'(1));
      end
      default: ;
    endcase
    wr_ptr_nxt = we ? wr_ptr + AW'(1) : wr_ptr;
  end

  // Word select within the sample under the read pointer (ring is frozen in READOUT)
  always_comb begin
    cur_sample = ring[rd_ptr];
    cur_word   = '0;
    for (int i = 0; i < W; i++)
      if (widx == WW'(i)) cur_word = cur_sample[i*DOUT_WIDTH +: DOUT_WIDTH];
  end

  // Sample storage; contents are don't-care after reset so no reset term
  always_ff @(posedge CLK) begin
    if (we) ring[wr_ptr] <= DIN;
  end

  // Capture FSM, miss counter and FWFT output stage
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state       <= ARMED;
      trig_q      <= 1'b0;
      wr_ptr      <= '0;
      fill        <= '0;
      post_rem    <= '0;
      rd_ptr      <= '0;
      rd_cnt      <= '0;
      widx        <= '0;
      prime       <= 1'b0;
      strm        <= 1'b0;
      src_done    <= 1'b0;
      DOUT        <= '0;
      DOUT_EMPTY  <= 1'b1;
      BUSY        <= 1'b0;
      TRIG_MISSED <= '0;
`ifdef DATA_SAMPLER_TIMESTAMP_EN
      ts_cnt      <= '0;
      ts_lat      <= '0;
      hdr         <= 1'b0;
`endif
    end else begin
      trig_q <= TRIG;
      if (missed_inc && (TRIG_MISSED != '1)) TRIG_MISSED <= TRIG_MISSED + CNT_WIDTH'(1);
`ifdef DATA_SAMPLER_TIMESTAMP_EN
      ts_cnt <= ts_cnt + DOUT_WIDTH'(1);
      if (accept) ts_lat <= ts_cnt;
`endif
      if (we) begin
        wr_ptr <= wr_ptr_nxt;
        if (fill != DEPTH_C) fill <= fill + (AW+1)'(1);
      end

      if (accept && !freeze) begin
        state    <= POST;
        BUSY     <= 1'b1;
        post_rem <= rem_a;
      end else if (state == POST && DIN_VALID && !freeze) begin
        post_rem <= post_rem - (AW+1)'(1);
      end

      // Freeze: oldest sample sits at the next write slot
      if (freeze) begin
        state    <= READOUT;
        BUSY     <= 1'b1;
        rd_ptr   <= wr_ptr_nxt;
        rd_cnt   <= '0;
        widx     <= '0;
        src_done <= 1'b0;
`ifdef DATA_SAMPLER_TIMESTAMP_EN
        hdr      <= 1'b1;
`endif
      end

      // One idle cycle after freeze so the first word lands two cycles later
      prime <= freeze;
      if (prime) strm <= 1'b1;

      if (strm) begin
        if (!src_done && (DOUT_EMPTY || DOUT_RDEN)) begin
          DOUT_EMPTY <= 1'b0;
`ifdef DATA_SAMPLER_TIMESTAMP_EN
          if (hdr) begin
            DOUT <= ts_lat;
            hdr  <= 1'b0;
          end else
`endif
          begin
            DOUT <= cur_word;
            if (widx == WW'(W-1)) begin
              widx   <= '0;
              rd_ptr <= rd_ptr + AW'(1);
              rd_cnt <= rd_cnt + AW'(1);
              if (rd_cnt == AW'(DEPTH-1)) src_done <= 1'b1;
            end else begin
              widx <= widx + WW'(1);
            end
          end
        end else if (src_done && !DOUT_EMPTY && DOUT_RDEN) begin
          // Last word popped: window closed, re-arm with an empty history
          DOUT_EMPTY <= 1'b1;
          strm       <= 1'b0;
          state      <= ARMED;
          BUSY       <= 1'b0;
          fill       <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_data_sampler_window_fifo.sv
// Scoreboard bench for data_sampler_window_fifo: expected words are queued when a
// trigger is issued; a negedge monitor pops and compares on every accepted read.
module tb_data_sampler_window_fifo;

  localparam int DIN_W  = 512;
  localparam int DOUT_W = 32;
  localparam int DEPTH  = 16;
  localparam int W      = DIN_W / DOUT_W;
  localparam int CW     = 2;
`ifdef DATA_SAMPLER_TIMESTAMP_EN
  localparam int WPW = 1 + DEPTH * W;
`else
  localparam int WPW = DEPTH * W;
`endif

  logic              CLK = 1'b0;
  logic              RESET = 1'b0;
  logic              TRIG = 1'b0;
  logic [DIN_W-1:0]  DIN = '0;
  logic              DIN_VALID = 1'b0;
  logic [4:0]        POST_CNT = 5'd4;
  logic [DOUT_W-1:0] DOUT;
  logic              DOUT_EMPTY;
  logic              DOUT_RDEN = 1'b0;
  logic              BUSY;
  logic [CW-1:0]     TRIG_MISSED;

  data_sampler_window_fifo #(
    .DIN_WIDTH(DIN_W), .DOUT_WIDTH(DOUT_W), .DEPTH(DEPTH), .CNT_WIDTH(CW)
  ) dut (
    .CLK(CLK), .RESET(RESET), .TRIG(TRIG), .DIN(DIN), .DIN_VALID(DIN_VALID),
    .POST_CNT(POST_CNT), .DOUT(DOUT), .DOUT_EMPTY(DOUT_EMPTY), .DOUT_RDEN(DOUT_RDEN),
    .BUSY(BUSY), .TRIG_MISSED(TRIG_MISSED)
  );

  always #5 CLK = ~CLK;

  logic [31:0] q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          pop_cnt = 0;
  int          win_pop0 = 0;
  int          cyc_i = 0;
  bit          rd_pat = 1'b0;
  logic [31:0] first_exp = '0;
  logic [31:0] mon_exp;
  logic [31:0] tb_cyc;

  // Reference free-running cycle counter for the timestamp header
  always @(posedge CLK or negedge RESET)
    if (!RESET) tb_cyc <= '0;
    else        tb_cyc <= tb_cyc + 32'd1;

  // Each lane carries {sample index, lane number} so word order is observable
  function automatic logic [DIN_W-1:0] samp(input int n);
    logic [DIN_W-1:0] s;
    for (int l = 0; l < W; l++) s[l*32 +: 32] = 32'((n << 8) | l);
    return s;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // Queue the window whose oldest sample index is s
  task automatic push_window(input int s);
    pop_cnt  = pop_cnt;
    win_pop0 = pop_cnt;
`ifdef DATA_SAMPLER_TIMESTAMP_EN
    q.push_back(tb_cyc);
`endif
    for (int k = 0; k < DEPTH * W; k++) q.push_back(32'(((s + k / W) << 8) | (k % W)));
    first_exp = q[0];
  endtask

  task automatic step(input bit v, input int n, input bit t);
    DIN       = samp(n);
    DIN_VALID = v;
    TRIG      = t;
    DOUT_RDEN = rd_pat ? ((cyc_i % 3) != 0) : 1'b1;
    cyc_i++;
    @(posedge CLK); #1;
  endtask

  task automatic do_reset(input int n);
    RESET = 1'b0; TRIG = 1'b0; DIN_VALID = 1'b0;
    q.delete();
    repeat (n) @(posedge CLK);
    #1 RESET = 1'b1;
  endtask

  // Run junk samples until the window drains; bounded
  task automatic wait_done(input string name, input int nstart);
    int n = nstart;
    for (int i = 0; i < 700; i++) begin
      step(1'b1, n, 1'b0);
      n++;
      if (!BUSY && DOUT_EMPTY) break;
    end
    chk({name, "_idle"}, {62'd0, BUSY, DOUT_EMPTY}, 64'd1);
    chk({name, "_left"}, 64'(q.size()), 64'd0);
    chk({name, "_words"}, 64'(pop_cnt - win_pop0), 64'(WPW));
  endtask

  // Monitor: compare every popped word against the scoreboard
  always @(negedge CLK) begin
    if (RESET && !DOUT_EMPTY && DOUT_RDEN) begin
      pop_cnt++;
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL dout_unexpected got %0h expected none", DOUT);
      end else begin
        mon_exp = q.pop_front();
        if (DOUT !== mon_exp) begin
          n_fail++;
          $display("FAIL dout_word got %0h expected %0h", DOUT, mon_exp);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    // Test 1: basic window, latency
    do_reset(3);
    chk("rst_empty", 64'(DOUT_EMPTY), 64'd1);
    chk("rst_busy", 64'(BUSY), 64'd0);
    chk("rst_missed", 64'(TRIG_MISSED), 64'd0);
    chk("rst_dout", 64'(DOUT), 64'd0);
    POST_CNT = 5'd4;
    for (int i = 0; i <= 20; i++) step(1'b1, i, 1'b0);
    push_window(9);
    step(1'b1, 21, 1'b1);
    chk("t1_busy_post", 64'(BUSY), 64'd1);
    step(1'b1, 22, 1'b0);
    step(1'b1, 23, 1'b0);
    step(1'b1, 24, 1'b0);
    chk("t1_lat0", 64'(DOUT_EMPTY), 64'd1);
    step(1'b1, 25, 1'b0);
    chk("t1_lat1", 64'(DOUT_EMPTY), 64'd1);
    step(1'b1, 26, 1'b0);
    chk("t1_lat2", 64'(DOUT_EMPTY), 64'd0);
    chk("t1_first", 64'(DOUT), 64'(first_exp));
    wait_done("t1", 27);

    // Test 2: early edge rejected, miss counter saturates
    do_reset(3);
    for (int i = 0; i < 3; i++) step(1'b1, i, 1'b0);
    step(1'b1, 3, 1'b1);
    step(1'b1, 4, 1'b0);
    step(1'b1, 5, 1'b0);
    chk("t2_missed", 64'(TRIG_MISSED), 64'd1);
    chk("t2_busy", 64'(BUSY), 64'd0);
    chk("t2_empty", 64'(DOUT_EMPTY), 64'd1);
    for (int i = 6; i < 12; i++) step(1'b1, i, (i % 2) == 0);
    chk("t2_sat", 64'(TRIG_MISSED), 64'd3);

    // Test 3: held trigger, edge during readout, readout data dropped
    do_reset(2);
    for (int i = 0; i < 20; i++) step(1'b1, i, 1'b0);
    push_window(8);
    for (int i = 0; i < 100; i++) step(1'b1, 20 + i, 1'b1);
    step(1'b1, 120, 1'b0);
    step(1'b1, 121, 1'b1);
    step(1'b1, 122, 1'b0);
    chk("t3_missed_ro", 64'(TRIG_MISSED), 64'd1);
    chk("t3_busy_ro", 64'(BUSY), 64'd1);
    wait_done("t3", 123);
    chk("t3_missed_end", 64'(TRIG_MISSED), 64'd1);
    for (int i = 0; i < 8; i++) step(1'b1, 5000 + i, 1'b0);
    step(1'b1, 5008, 1'b1);
    step(1'b1, 5009, 1'b0);
    chk("t3_fill_reset", 64'(TRIG_MISSED), 64'd2);
    for (int i = 5010; i < 5014; i++) step(1'b1, i, 1'b0);
    push_window(5002);
    step(1'b1, 5014, 1'b1);
    for (int i = 5015; i < 5018; i++) step(1'b1, i, 1'b0);
    wait_done("t3b", 5018);

    // Test 4: POST_CNT boundaries, with read backpressure
    do_reset(2);
    rd_pat = 1'b1;
    POST_CNT = 5'd0;
    for (int i = 0; i < 20; i++) step(1'b1, i, 1'b0);
    push_window(4);
    step(1'b1, 20, 1'b1);
    chk("t4_busy0", 64'(BUSY), 64'd1);
    step(1'b1, 21, 1'b0);
    chk("t4_lat1", 64'(DOUT_EMPTY), 64'd1);
    step(1'b1, 22, 1'b0);
    chk("t4_lat2", 64'(DOUT_EMPTY), 64'd0);
    wait_done("t4a", 23);
    POST_CNT = 5'd16;
    push_window(100);
    step(1'b1, 100, 1'b1);
    for (int i = 101; i < 116; i++) step(1'b1, i, 1'b0);
    wait_done("t4b", 116);
    rd_pat = 1'b0;

    // Test 5: reset mid-readout, then fresh window
    do_reset(2);
    POST_CNT = 5'd4;
    for (int i = 0; i <= 20; i++) step(1'b1, i, 1'b0);
    push_window(9);
    step(1'b1, 21, 1'b1);
    n = 22;
    for (int i = 0; i < 400; i++) begin
      if (pop_cnt - win_pop0 >= 100) break;
      step(1'b1, n, 1'b0);
      n++;
    end
    chk("t5_pops", 64'(pop_cnt - win_pop0), 64'd100);
    RESET = 1'b0;
    #1;
    chk("t5_rst_empty", 64'(DOUT_EMPTY), 64'd1);
    chk("t5_rst_busy", 64'(BUSY), 64'd0);
    q.delete();
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b1;
    for (int i = 0; i < 11; i++) step(1'b1, i, 1'b0);
    step(1'b1, 11, 1'b1);
    step(1'b1, 12, 1'b0);
    chk("t5_refill_rej", 64'(TRIG_MISSED), 64'd1);
    push_window(1);
    step(1'b1, 13, 1'b1);
    for (int i = 14; i < 17; i++) step(1'b1, i, 1'b0);
    wait_done("t5b", 17);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
